// File: rtl/rt_ibex_hws_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rt_ibex_hws_pkg / rt_ibex_hws_seq_if
//  Description : Stacking-mode type and the handshake interface between the
//                core controller / hardware stacking unit and the sequencer.
//                Port summary (names are seen from the sequencer):
//                  entry_req_i / exit_req_i  : controller requests (level)
//                  entry_gnt_o / exit_gnt_o  : grant pulses back to controller
//                  tail_chain_o              : tail-chain pulse
//                  hws_start_o / hws_mode_o  : start pulse and mode to stacker
//                  hws_ack_o / hws_done_i    : ack pulse / registered done
//                  depth_o                   : nesting depth
//                  err_o / err_code_o        : sticky error and its cause
//  Revision    : 1.0 - initial release
// ============================================================================

package rt_ibex_hws_pkg;
    typedef enum logic {
        HWS_SAVE    = 1'b0,
        HWS_RESTORE = 1'b1
    } hw_stacking_mode_t;
endpackage

interface rt_ibex_hws_seq_if #(
    parameter int MAX_NEST = 4
);
    import rt_ibex_hws_pkg::*;

    localparam int DW = $clog2(MAX_NEST + 1);

    logic              entry_req_i;
    logic              exit_req_i;
    logic              entry_gnt_o;
    logic              exit_gnt_o;
    logic              tail_chain_o;
    logic              hws_start_o;
    hw_stacking_mode_t hws_mode_o;
    logic              hws_ack_o;
    logic              hws_done_i;
    logic [DW-1:0]     depth_o;
    logic              err_o;
    logic [1:0]        err_code_o;

    // Controller + stacking unit side
    modport master (
        output entry_req_i, exit_req_i, hws_done_i,
        input  entry_gnt_o, exit_gnt_o, tail_chain_o, hws_start_o,
               hws_mode_o, hws_ack_o, depth_o, err_o, err_code_o
    );

    // Sequencer side
    modport slave (
        input  entry_req_i, exit_req_i, hws_done_i,
        output entry_gnt_o, exit_gnt_o, tail_chain_o, hws_start_o,
               hws_mode_o, hws_ack_o, depth_o, err_o, err_code_o
    );
endinterface

`default_nettype wire

// File: rtl/rt_ibex_hws_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rt_ibex_hws_seq
//  Description : Sequencer in front of the RT-IBEX hardware stacking unit.
//                Converts interrupt-entry / mret-exit requests into SAVE and
//                RESTORE stacking runs, short-circuits tail-chains, tracks
//                nesting depth and flags overflow/underflow/timeout errors.
//                Ports:
//                  clk_i  : clock
//                  rst_i  : synchronous active-high reset
//                  bus    : rt_ibex_hws_seq_if.slave handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================

module rt_ibex_hws_seq
    import rt_ibex_hws_pkg::*;
#(
    parameter int MAX_NEST = 4,   // 1..15
    parameter int TIMEOUT  = 64   // 2..255
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    rt_ibex_hws_seq_if.slave    bus
);

    localparam int DW = $clog2(MAX_NEST + 1);

    localparam logic [DW-1:0] C_DEPTH_MAX = DW'(MAX_NEST);
    localparam logic [7:0]    C_TIMEOUT   = 8'(TIMEOUT);

    localparam logic [1:0] C_ERR_OVF = 2'b01;
    localparam logic [1:0] C_ERR_UNF = 2'b10;
    localparam logic [1:0] C_ERR_TO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_GUARD = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            state_q;
    hw_stacking_mode_t mode_q;
    logic [DW-1:0]     depth_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic              w_tail;
    logic              w_ack;

    // Counter value one cycle after the current one
    assign cnt_d = cnt_q + 8'd1;

    // Both requests in IDLE: hand over directly to the next handler
    assign w_tail = (state_q == S_IDLE) && bus.entry_req_i && bus.exit_req_i;
    // Done is only honoured in WAIT; in GUARD it is the stale registered level
    assign w_ack  = (state_q == S_WAIT) && bus.hws_done_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mode_q     <= HWS_SAVE;
            depth_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!(bus.entry_req_i && bus.exit_req_i)) begin
                        if (bus.exit_req_i && (depth_q == '0)) begin
                            err_q      <= 1'b1;
                            err_code_q <= C_ERR_UNF;
                            state_q    <= S_ERROR;
                        end else if (bus.entry_req_i && (depth_q == C_DEPTH_MAX)) begin
                            err_q      <= 1'b1;
                            err_code_q <= C_ERR_OVF;
                            state_q    <= S_ERROR;
                        end else if (bus.entry_req_i) begin
                            mode_q  <= HWS_SAVE;
                            state_q <= S_START;
                        end else if (bus.exit_req_i) begin
                            mode_q  <= HWS_RESTORE;
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    // The start cycle itself counts as the first elapsed
                    // cycle, so the counter holds cycles-since-start in WAIT.
                    cnt_q   <= 8'd1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.hws_done_i) begin
                        if (mode_q == HWS_SAVE) begin
                            depth_q <= depth_q + 1'b1;
                        end else begin
                            depth_q <= depth_q - 1'b1;
                        end
                        state_q <= S_GUARD;
                    end else if (cnt_d == C_TIMEOUT) begin
                        err_q      <= 1'b1;
                        err_code_q <= C_ERR_TO;
                        state_q    <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_GUARD: begin
                    state_q <= S_IDLE;
                end
                S_ERROR: begin
                    state_q <= S_ERROR;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hws_start_o  = (state_q == S_START);
    assign bus.hws_ack_o    = w_ack;
    assign bus.hws_mode_o   = mode_q;
    assign bus.tail_chain_o = w_tail;
    assign bus.entry_gnt_o  = w_tail || (w_ack && (mode_q == HWS_SAVE));
    assign bus.exit_gnt_o   = w_tail || (w_ack && (mode_q == HWS_RESTORE));
    assign bus.depth_o      = depth_q;
    assign bus.err_o        = err_q;
    assign bus.err_code_o   = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_rt_ibex_hws_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rt_ibex_hws_seq
//  Description : Directed self-checking bench for rt_ibex_hws_seq. One DUT
//                with MAX_NEST=2 / TIMEOUT=64 covers save, restore, tail-chain,
//                nesting limits and reset mid-run; a second DUT with
//                TIMEOUT=8 covers the stacking timeout.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_rt_ibex_hws_seq;
    import rt_ibex_hws_pkg::*;

    logic clk;
    logic rst;

    int n_chk;
    int n_fail;
    int cyc;
    int last_ack;
    int m_depth;

    typedef struct {
        bit is_save;
        int depth;
    } exp_t;

    exp_t exp_q[$];

    rt_ibex_hws_seq_if #(.MAX_NEST(2)) bus ();
    rt_ibex_hws_seq_if #(.MAX_NEST(4)) bus_t ();

    rt_ibex_hws_seq #(.MAX_NEST(2), .TIMEOUT(64)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    rt_ibex_hws_seq #(.MAX_NEST(4), .TIMEOUT(8)) u_dut_t (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"},   bus.hws_start_o,  0);
        chk({tag, "_ack"},     bus.hws_ack_o,    0);
        chk({tag, "_egnt"},    bus.entry_gnt_o,  0);
        chk({tag, "_xgnt"},    bus.exit_gnt_o,   0);
        chk({tag, "_tail"},    bus.tail_chain_o, 0);
        chk({tag, "_mode"},    bus.hws_mode_o,   HWS_SAVE);
        chk({tag, "_depth"},   bus.depth_o,      0);
        chk({tag, "_err"},     bus.err_o,        0);
        chk({tag, "_errcode"}, bus.err_code_o,   0);
    endtask

    task automatic do_reset();
        bus.entry_req_i = 1'b0;
        bus.exit_req_i  = 1'b0;
        bus.hws_done_i  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_depth = 0;
        exp_q.delete();
        #1;
    endtask

    // One full stacking run on the main DUT, starting in an IDLE cycle.
    // Returns in the IDLE cycle after GUARD with requests and done low.
    task automatic serve(input bit is_save, input int lat, input bit chained);
        exp_t e;
        bit   got;
        int   t_start;
        got = 1'b0;
        e.is_save = is_save;
        e.depth   = is_save ? m_depth + 1 : m_depth - 1;
        exp_q.push_back(e);
        if (is_save) bus.entry_req_i = 1'b1;
        else         bus.exit_req_i  = 1'b1;
        #1;
        chk("start_in_req_cycle", bus.hws_start_o, 0);
        tick();
        chk("start_pulse", bus.hws_start_o, 1);
        chk("mode_at_start", bus.hws_mode_o, is_save ? HWS_SAVE : HWS_RESTORE);
        t_start = cyc;
        if (chained) chk("ack_to_start_gap", t_start - last_ack, 3);
        for (int k = 1; k <= lat + 2 && !got; k++) begin
            tick();
            bus.hws_done_i = (k == lat);
            #1;
            if (bus.hws_ack_o) begin
                got      = 1'b1;
                last_ack = cyc;
                e        = exp_q.pop_front();
                chk("ack_latency", k, lat);
                chk("entry_gnt", bus.entry_gnt_o, e.is_save);
                chk("exit_gnt", bus.exit_gnt_o, !e.is_save);
                chk("mode_at_ack", bus.hws_mode_o, e.is_save ? HWS_SAVE : HWS_RESTORE);
                m_depth = e.depth;
            end
        end
        chk("ack_seen", got, 1);
        if (!got) exp_q.delete();
        tick();
        bus.entry_req_i = 1'b0;
        bus.exit_req_i  = 1'b0;
        #1;
        chk("guard_no_ack", bus.hws_ack_o, 0);
        chk("depth_after_run", bus.depth_o, m_depth);
        tick();
        bus.hws_done_i = 1'b0;
        #1;
    endtask

    initial begin
        int starts;
        int acks;
        int errs;
        int t_s;
        n_chk    = 0;
        n_fail   = 0;
        cyc      = 0;
        last_ack = 0;
        m_depth  = 0;
        bus_t.entry_req_i = 1'b0;
        bus_t.exit_req_i  = 1'b0;
        bus_t.hws_done_i  = 1'b0;

        // Reset values
        bus.entry_req_i = 1'b0;
        bus.exit_req_i  = 1'b0;
        bus.hws_done_i  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        do_reset();
        chk_reset("reset");
        chk("reset_t_err", bus_t.err_o, 0);
        chk("reset_t_depth", bus_t.depth_o, 0);

        // Single save, stacker done 10 cycles after start
        serve(1'b1, 10, 1'b0);
        // Save then restore, back-to-back
        serve(1'b0, 5, 1'b1);
        // Save to depth 1
        serve(1'b1, 3, 1'b1);

        // Tail-chain at depth 1
        bus.entry_req_i = 1'b1;
        bus.exit_req_i  = 1'b1;
        #1;
        chk("tc_entry_gnt", bus.entry_gnt_o, 1);
        chk("tc_exit_gnt", bus.exit_gnt_o, 1);
        chk("tc_pulse", bus.tail_chain_o, 1);
        chk("tc_no_start_same", bus.hws_start_o, 0);
        tick();
        bus.entry_req_i = 1'b0;
        bus.exit_req_i  = 1'b0;
        #1;
        chk("tc_no_start_next", bus.hws_start_o, 0);
        chk("tc_gnt_one_cycle", bus.entry_gnt_o, 0);
        chk("tc_depth", bus.depth_o, m_depth);

        // Nesting overflow with MAX_NEST=2
        serve(1'b1, 2, 1'b0);
        chk("depth_at_max", bus.depth_o, 2);
        bus.entry_req_i = 1'b1;
        #1;
        chk("ovf_no_gnt", bus.entry_gnt_o, 0);
        tick();
        chk("ovf_err", bus.err_o, 1);
        chk("ovf_code", bus.err_code_o, 2'b01);
        starts = 0;
        acks   = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.hws_done_i = (k == 2);
            #1;
            starts += bus.hws_start_o;
            acks   += bus.hws_ack_o + bus.entry_gnt_o + bus.exit_gnt_o;
        end
        chk("ovf_no_starts", starts, 0);
        chk("ovf_no_acks", acks, 0);
        chk("ovf_code_sticky", bus.err_code_o, 2'b01);

        // Underflow from reset
        do_reset();
        chk_reset("reset2");
        bus.exit_req_i = 1'b1;
        #1;
        chk("unf_no_gnt", bus.exit_gnt_o, 0);
        tick();
        chk("unf_err", bus.err_o, 1);
        chk("unf_code", bus.err_code_o, 2'b10);
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            starts += bus.hws_start_o;
        end
        chk("unf_no_starts", starts, 0);

        // Reset in the middle of a run
        do_reset();
        bus.entry_req_i = 1'b1;
        tick();
        chk("mid_start", bus.hws_start_o, 1);
        tick();
        tick();
        bus.entry_req_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_reset("mid_reset");
        m_depth = 0;
        exp_q.delete();
        serve(1'b1, 4, 1'b0);

        // Timeout on the TIMEOUT=8 instance
        bus_t.entry_req_i = 1'b1;
        tick();
        chk("to_start", bus_t.hws_start_o, 1);
        t_s  = cyc;
        acks = 0;
        errs = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            #1;
            acks += bus_t.hws_ack_o;
            errs += bus_t.err_o;
        end
        chk("to_no_early_err", errs, 0);
        chk("to_no_ack", acks, 0);
        tick();
        chk("to_cycles_from_start", cyc - t_s, 8);
        chk("to_err", bus_t.err_o, 1);
        chk("to_code", bus_t.err_code_o, 2'b11);
        chk("to_no_ack_at_err", bus_t.hws_ack_o, 0);
        bus_t.entry_req_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
